// File: rtl/avalon_mm_read_master_if.sv
// Avalon-MM pipelined read bus between the read master and its slave.
//
// Handshake: a read is accepted on a rising edge where master_read=1 and
// master_waitrequest=0. Address and master_read are held while waitrequest
// is high. Each accepted read returns exactly one word, flagged by
// master_readdatavalid, in the order the reads were accepted. The master
// never back-pressures read data.
interface avalon_mm_read_master_if #(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32
);
    logic [ADDRESSWIDTH-1:0]    master_address;
    logic                       master_read;
    logic [BYTEENABLEWIDTH-1:0] master_byteenable;
    logic [DATAWIDTH-1:0]       master_readdata;
    logic                       master_waitrequest;
    logic                       master_readdatavalid;

    modport master (
        output master_address,
        output master_read,
        output master_byteenable,
        input  master_readdata,
        input  master_waitrequest,
        input  master_readdatavalid
    );

    modport slave (
        input  master_address,
        input  master_read,
        input  master_byteenable,
        output master_readdata,
        output master_waitrequest,
        output master_readdatavalid
    );
endinterface

// File: rtl/avalon_mm_read_master.sv
// Avalon-MM pipelined read master with a show-ahead receive FIFO.
// A go pulse loads base/length/fixed; reads are issued one word at a time
// and are only issued when a FIFO slot is reserved for the response, so
// returning data can never overflow the buffer.
module avalon_mm_read_master #(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0] control_read_base,
    input  logic [ADDRESSWIDTH-1:0] control_read_length,
    input  logic                    control_go,
    output logic                    control_done,
    input  logic                    user_read_buffer,
    output logic [DATAWIDTH-1:0]    user_buffer_data,
    output logic                    user_data_available,
    avalon_mm_read_master_if.master avm
);

    localparam int CW = FIFODEPTH_LOG2 + 1;
    localparam logic [ADDRESSWIDTH-1:0] STRIDE = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFODEPTH);

    logic [ADDRESSWIDTH-1:0]   address;
    logic [ADDRESSWIDTH-1:0]   length;
    logic                      fixed;
    logic [CW-1:0]             pending;
    logic [CW-1:0]             fifo_used;
    logic [FIFODEPTH_LOG2-1:0] wr_ptr;
    logic [FIFODEPTH_LOG2-1:0] rd_ptr;
    logic [DATAWIDTH-1:0]      fifo_mem [FIFODEPTH];

    logic [CW:0] occupancy;
    logic        read_req;
    logic        accept;
    logic        push;
    logic        pop;

    // Words already buffered plus words still in flight; one extra bit so
    // the sum can never wrap.
    assign occupancy = {1'b0, fifo_used} + {1'b0, pending};
    assign read_req  = (length != '0) && (occupancy < DEPTH_W);
    assign accept    = read_req && !avm.master_waitrequest;
    assign push      = avm.master_readdatavalid;
    assign pop       = user_read_buffer && (fifo_used != '0);

    assign avm.master_address    = address;
    assign avm.master_read       = read_req;
    assign avm.master_byteenable = '1;

    assign control_done        = (length == '0) && (pending == '0);
    assign user_buffer_data    = fifo_mem[rd_ptr];
    assign user_data_available = (fifo_used != '0);

    // Transfer descriptor: go loads it, each accepted read advances it.
    always_ff @(posedge clk) begin
        if (reset) begin
            address <= '0;
            length  <= '0;
            fixed   <= 1'b0;
        end else if (control_go) begin
            address <= control_read_base;
            length  <= control_read_length;
            fixed   <= control_fixed_location;
        end else if (accept) begin
            length <= length - STRIDE;
            if (!fixed) begin
                address <= address + STRIDE;
            end
        end
    end

    // Reads accepted but whose data has not yet returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({accept, push})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // Circular-buffer pointers and word count; a pop on an empty FIFO is a no-op.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_used <= fifo_used + 1'b1;
                2'b01:   fifo_used <= fifo_used - 1'b1;
                default: fifo_used <= fifo_used;
            endcase
        end
    end

    // Response storage; data arriving while in reset is discarded.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr] <= avm.master_readdata;
        end
    end

endmodule

// File: tb/tb_avalon_mm_read_master.sv
// Bench for avalon_mm_read_master: a latency-modelling slave, a user-side
// popper and a queue-based reference of outstanding addresses, in-flight
// responses and buffered words.
module tb_avalon_mm_read_master;

    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int AW    = 32;
    localparam int DEPTH = 32;
    localparam int LOG2  = 5;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } resp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          control_fixed_location;
    logic [AW-1:0] control_read_base;
    logic [AW-1:0] control_read_length;
    logic          control_go;
    logic          control_done;
    logic          user_read_buffer;
    logic [DW-1:0] user_buffer_data;
    logic          user_data_available;

    avalon_mm_read_master_if #(.DATAWIDTH(DW), .BYTEENABLEWIDTH(BW), .ADDRESSWIDTH(AW)) bus ();

    avalon_mm_read_master #(
        .DATAWIDTH(DW), .BYTEENABLEWIDTH(BW), .ADDRESSWIDTH(AW),
        .FIFODEPTH(DEPTH), .FIFODEPTH_LOG2(LOG2)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .control_fixed_location (control_fixed_location),
        .control_read_base      (control_read_base),
        .control_read_length    (control_read_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_read_buffer       (user_read_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_data_available    (user_data_available),
        .avm                    (bus)
    );

    // ---------------- reference model state ----------------
    logic [AW-1:0] addr_q[$];   // reads still to be accepted, in order
    resp_t         resp_q[$];   // accepted reads awaiting their response
    logic [DW-1:0] exp_q[$];    // words delivered to the FIFO, not yet popped

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int accepts = 0;
    int last_due = 0;
    int wr_pct = 0;
    int pop_pct = 100;
    int lat_min = 2;
    int lat_max = 2;
    bit pop_when_empty = 1'b0;
    bit hold_wr = 1'b0;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: compare outputs against the model, then drive the next inputs.
    task automatic tick();
        bit    wr;
        bit    pop;
        int    due;
        resp_t r;
        check("master_read", 64'(bus.master_read),
              64'(addr_q.size() != 0 && (exp_q.size() + resp_q.size()) < DEPTH));
        check("control_done", 64'(control_done), 64'(addr_q.size() == 0 && resp_q.size() == 0));
        check("data_available", 64'(user_data_available), 64'(exp_q.size() != 0));
        check("byteenable", 64'(bus.master_byteenable), 64'(4'hF));
        if (bus.master_read && addr_q.size() != 0)
            check("master_address", 64'(bus.master_address), 64'(addr_q[0]));

        // Control inputs are don't-care without go.
        control_read_base      = $urandom;
        control_read_length    = $urandom;
        control_fixed_location = 1'($urandom_range(0, 1));

        pop = ($urandom_range(0, 99) < pop_pct) && (exp_q.size() != 0 || pop_when_empty);
        user_read_buffer = pop;
        if (pop && exp_q.size() != 0)
            check("pop_data", 64'(user_buffer_data), 64'(exp_q.pop_front()));

        wr = hold_wr || ($urandom_range(0, 99) < wr_pct);
        bus.master_waitrequest = wr;
        if (bus.master_read && !wr) begin
            accepts++;
            if (addr_q.size() != 0) void'(addr_q.pop_front());
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due  = due;
            r.data = $urandom;
            resp_q.push_back(r);
        end

        if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
            r = resp_q.pop_front();
            bus.master_readdatavalid = 1'b1;
            bus.master_readdata      = r.data;
            exp_q.push_back(r.data);
        end else begin
            bus.master_readdatavalid = 1'b0;
            bus.master_readdata      = $urandom;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic start(input logic [AW-1:0] base, input int len, input bit fx);
        control_read_base      = base;
        control_read_length    = AW'(len);
        control_fixed_location = fx;
        control_go             = 1'b1;
        bus.master_waitrequest   = 1'b0;
        bus.master_readdatavalid = 1'b0;
        user_read_buffer         = 1'b0;
        @(negedge clk);
        cyc++;
        control_go = 1'b0;
        for (int i = 0; i < len / BW; i++)
            addr_q.push_back(fx ? base : base + AW'(BW * i));
    endtask

    task automatic do_reset(input int n, input bit with_rdv);
        reset                  = 1'b1;
        control_go             = 1'b0;
        bus.master_waitrequest = 1'b0;
        user_read_buffer       = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.master_readdatavalid = with_rdv;
            bus.master_readdata      = $urandom;
            @(negedge clk);
            cyc++;
        end
        reset = 1'b0;
        bus.master_readdatavalid = 1'b0;
        addr_q.delete();
        resp_q.delete();
        exp_q.delete();
        last_due = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((addr_q.size() != 0 || resp_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("idle_within_budget", 64'(n < budget), 64'(1));
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        int len;
        logic [AW-1:0] base;
        bit fx;

        reset = 1'b1;
        control_fixed_location = 1'b0;
        control_read_base = '0;
        control_read_length = '0;
        control_go = 1'b0;
        user_read_buffer = 1'b0;
        bus.master_readdata = '0;
        bus.master_waitrequest = 1'b0;
        bus.master_readdatavalid = 1'b0;

        // Reset state, with responses arriving during reset.
        do_reset(3, 1'b1);
        check("rst_done", 64'(control_done), 64'(1));
        check("rst_read", 64'(bus.master_read), 64'(0));
        check("rst_address", 64'(bus.master_address), 64'(0));
        check("rst_avail", 64'(user_data_available), 64'(0));

        // Basic 4-word transfer, latency 2, no waitrequest.
        wr_pct = 0; pop_pct = 100; lat_min = 2; lat_max = 2; pop_when_empty = 1'b0;
        a0 = accepts;
        start(32'h100, 16, 1'b0);
        wait_idle(200);
        check("basic_accepts", 64'(accepts - a0), 64'(4));
        check("basic_done", 64'(control_done), 64'(1));

        // Fixed address, 3 words.
        a0 = accepts;
        start(32'h0000_0A40, 12, 1'b1);
        wait_idle(200);
        check("fixed_accepts", 64'(accepts - a0), 64'(3));

        // Zero-length go issues nothing.
        a0 = accepts;
        start(32'h0000_0800, 0, 1'b0);
        repeat (5) tick();
        check("zero_len_accepts", 64'(accepts - a0), 64'(0));
        check("zero_len_done", 64'(control_done), 64'(1));

        // No popping: reads stop once the FIFO is fully reserved.
        wr_pct = 20; pop_pct = 0; lat_min = 1; lat_max = 3;
        a0 = accepts;
        start(32'h1000, 256, 1'b0);
        repeat (150) tick();
        check("full_accepts", 64'(accepts - a0), 64'(DEPTH));
        check("full_read_low", 64'(bus.master_read), 64'(0));
        check("full_avail", 64'(user_data_available), 64'(1));
        pop_pct = 100;
        tick();
        pop_pct = 0;
        repeat (30) tick();
        check("one_pop_one_read", 64'(accepts - a0), 64'(DEPTH + 1));
        pop_pct = 70;
        wait_idle(3000);
        check("full_total_accepts", 64'(accepts - a0), 64'(64));

        // Waitrequest held for 5 cycles.
        wr_pct = 0; pop_pct = 100; lat_min = 2; lat_max = 2;
        hold_wr = 1'b1;
        a0 = accepts;
        start(32'h2000, 16, 1'b0);
        repeat (5) begin
            tick();
            check("wait_read_held", 64'(bus.master_read), 64'(1));
            check("wait_addr_held", 64'(bus.master_address), 64'(32'h2000));
        end
        check("wait_no_accept", 64'(accepts - a0), 64'(0));
        hold_wr = 1'b0;
        tick();
        check("wait_one_accept", 64'(accepts - a0), 64'(1));
        wait_idle(200);

        // Randomised transfers: long ones wrap the FIFO pointers.
        pop_when_empty = 1'b1;
        repeat (8) begin
            base    = $urandom & 32'hFFFF_FFFC;
            len     = BW * $urandom_range(0, 100);
            fx      = ($urandom_range(0, 3) == 0);
            wr_pct  = $urandom_range(0, 60);
            pop_pct = $urandom_range(20, 100);
            lat_min = $urandom_range(1, 3);
            lat_max = lat_min + $urandom_range(0, 4);
            a0 = accepts;
            start(base, len, fx);
            wait_idle(4000);
            check("rand_accepts", 64'(accepts - a0), 64'(len / BW));
        end

        // Reset mid-transfer with three reads outstanding.
        wr_pct = 0; pop_pct = 0; lat_min = 3; lat_max = 3; pop_when_empty = 1'b0;
        start(32'h400, 64, 1'b0);
        begin
            int n = 0;
            while (resp_q.size() != 3 && n < 50) begin
                tick();
                n++;
            end
        end
        check("pending_reached_3", 64'(resp_q.size()), 64'(3));
        do_reset(2, 1'b1);
        check("midrst_done", 64'(control_done), 64'(1));
        check("midrst_read", 64'(bus.master_read), 64'(0));
        check("midrst_avail", 64'(user_data_available), 64'(0));
        check("midrst_address", 64'(bus.master_address), 64'(0));
        pop_pct = 50; pop_when_empty = 1'b1;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
